l1_wb_cache: RTL and testbench
==============================

Name: l1_wb_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache for one CPU wishbone port (instruction or data).
- CPU side: wishbone slave with 12-bit line address, 128-bit line data and 16-bit byte select. Memory side: wishbone master to the L2.
- Instantiated twice, as icache and dcache. Its hit and miss counters drive the datapath's icache/dcache counter inputs.

Parameters:
- SET_BITS, 3, log2 of line count (8 lines); the tag is the upper 12-SET_BITS bits of the address.
- CNT_WIDTH, 16, width of the hit and miss counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- cpu_adr  input  12  line address
- cpu_dat_m  input  128  write data from the CPU
- cpu_dat_s  output  128  read data to the CPU
- cpu_sel  input  16  byte enables for writes
- cpu_we  input  1  write request
- cpu_stb  input  1  strobe
- cpu_cyc  input  1  cycle valid
- cpu_ack  output  1  request complete
- mem_adr  output  12  line address to the L2
- mem_dat_m  output  128  victim line to the L2
- mem_dat_s  input  128  fill line from the L2
- mem_sel  output  16  always 16'hFFFF while mem_stb is high
- mem_we  output  1  write to the L2
- mem_stb  output  1  strobe to the L2
- mem_cyc  output  1  cycle to the L2
- mem_ack  input  1  response from the L2
- hit_count  output  CNT_WIDTH  requests that hit
- miss_count  output  CNT_WIDTH  requests that missed

Behaviour:
- Request: a request is valid when cpu_stb & cpu_cyc. The CPU holds adr, we, sel and dat_m stable until cpu_ack.
- Storage per set: valid, dirty, tag, 128-bit data.
- States: COMPARE, WRITEBACK, FILL. Reset state is COMPARE.
- COMPARE, hit (valid & tag match):
  - cpu_ack = 1 combinationally in the same cycle.
  - Read: cpu_dat_s = line data.
  - Write: at the clock edge, bytes with cpu_sel[i]=1 are merged into the line and dirty is set.
  - Zero-wait hit, so back-to-back hits ack every cycle.
- COMPARE, miss:
  - cpu_ack = 0.
  - Next state is WRITEBACK if the set is valid & dirty, otherwise FILL.
  - miss_count increments once, on that edge.
- WRITEBACK:
  - mem_stb = mem_cyc = mem_we = 1; mem_adr = {victim tag, set}; mem_dat_m = victim line.
  - Held until mem_ack, then dirty is cleared and next state is FILL.
- FILL:
  - mem_stb = mem_cyc = 1, mem_we = 0, mem_adr = cpu_adr.
  - On mem_ack: mem_dat_s is written into the line, valid = 1, dirty = 0, tag updated; next state is COMPARE.
- Miss completion: the pending request then hits in COMPARE, so miss latency is 1 + writeback (if any) + fill + 1 cycles. A write miss merges on that hit.
- Hit counting:
  - hit_count increments on a COMPARE hit that is acked, except the replay hit immediately after a FILL. A first-presentation flag distinguishes the two.
  - Each request counts exactly once, as either a hit or a miss.
- Counters: wrap modulo 2^CNT_WIDTH.
- Idle outputs: cpu_dat_s = line data of the addressed set when not hitting; mem_dat_m = 0 when not in WRITEBACK.
- CPU abandons a request (stb drops) during WRITEBACK or FILL: the L2 transaction completes, the line is installed and the FSM returns to COMPARE. No ack is issued and no extra count is recorded.
- mem_ack outside WRITEBACK/FILL: ignored.
- Reset (any state, including mid-transaction):
  - State goes to COMPARE; all valid and dirty bits are cleared; dirty data is lost.
  - mem_stb, mem_cyc, mem_we, cpu_ack = 0; hit_count = miss_count = 0.
  - Data arrays are not required to be cleared.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- Defined: hit_count and miss_count behave as above.
- Undefined: no counter flops are built; hit_count and miss_count are tied to 0.

Test Plan:
- Reset, then read adr 12'h010 (set 0) with L2 returning line 128'hA5...A5 after 3 cycles -> one FILL transaction at mem_adr=12'h010, no WRITEBACK, cpu_ack one cycle after the mem_ack edge, cpu_dat_s=A5..A5, miss_count=1, hit_count=0.
- Read 12'h010 again -> cpu_ack in the same cycle, no mem_stb, hit_count=1.
- Write 12'h010 with sel=16'h0003, dat_m low half-word 16'hBEEF -> same-cycle ack. A subsequent read returns bytes [1:0]=BEEF and other bytes unchanged.
- Read 12'h018 (same set, different tag) -> WRITEBACK to 12'h010 carrying the BEEF-merged line with mem_we=1, then FILL of 12'h018; miss_count=2.
- Back-to-back hits on 12'h018 for 4 cycles -> cpu_ack high all 4 cycles, hit_count +4.
- Assert rst during FILL before mem_ack -> next cycle mem_stb=0, both counters 0, read 12'h018 misses again. With L1_CACHE_STATS_EN undefined, both counters read 0 throughout.

Source files
------------

// File: rtl/l1_wb_cache.sv
// rtl/l1_wb_cache.sv - direct-mapped write-back write-allocate L1 cache; hit/miss counters built only with L1_CACHE_STATS_EN
module l1_wb_cache #(
  parameter int SET_BITS  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [11:0]          cpu_adr,
  input  logic [127:0]         cpu_dat_m,
  output logic [127:0]         cpu_dat_s,
  input  logic [15:0]          cpu_sel,
  input  logic                 cpu_we,
  input  logic                 cpu_stb,
  input  logic                 cpu_cyc,
  output logic                 cpu_ack,
  output logic [11:0]          mem_adr,
  output logic [127:0]         mem_dat_m,
  input  logic [127:0]         mem_dat_s,
  output logic [15:0]          mem_sel,
  output logic                 mem_we,
  output logic                 mem_stb,
  output logic                 mem_cyc,
  input  logic                 mem_ack,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);
  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = 12 - SET_BITS;

  typedef enum logic [1:0] {COMPARE, WRITEBACK, FILL} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SETS-1:0]       r_valid;
  logic [SETS-1:0]       r_dirty;
  logic [TAG_W-1:0]      r_tag  [SETS];
  logic [127:0]          r_data [SETS];
  logic [11:0]           r_miss_adr;

  logic                  w_req;
  logic [SET_BITS-1:0]   w_set;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [SET_BITS-1:0]   w_miss_set;
  logic                  w_cmp_hit;
  logic                  w_cmp_miss;
  logic                  w_wb_done;
  logic                  w_fill_done;
  logic [127:0]          w_merged;

  assign w_req       = cpu_stb & cpu_cyc;
  assign w_set       = cpu_adr[SET_BITS-1:0];
  assign w_tag       = cpu_adr[11:SET_BITS];
  assign w_hit       = r_valid[w_set] && (r_tag[w_set] == w_tag);
  assign w_miss_set  = r_miss_adr[SET_BITS-1:0];
  assign w_cmp_hit   = !rst && (r_state == COMPARE) && w_req && w_hit;
  assign w_cmp_miss  = !rst && (r_state == COMPARE) && w_req && !w_hit;
  assign w_wb_done   = (r_state == WRITEBACK) && mem_ack;
  assign w_fill_done = (r_state == FILL) && mem_ack;
  assign cpu_dat_s   = r_data[w_set];

  // byte-merge of CPU write data into the addressed line
  always_comb begin
    w_merged = r_data[w_set];
    for (int i = 0; i < 16; i++) begin
      if (cpu_sel[i]) w_merged[8*i +: 8] = cpu_dat_m[8*i +: 8];
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= COMPARE;
    else     r_state <= w_next;
  end

  // next state and bus outputs; reset forces every handshake low
  always_comb begin
    w_next    = r_state;
    cpu_ack   = 1'b0;
    mem_adr   = 12'h000;
    mem_dat_m = 128'h0;
    mem_we    = 1'b0;
    mem_stb   = 1'b0;
    mem_cyc   = 1'b0;
    case (r_state)
      COMPARE: begin
        cpu_ack = w_req & w_hit;
        if (w_req && !w_hit)
          w_next = (r_valid[w_set] && r_dirty[w_set]) ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        mem_stb   = 1'b1;
        mem_cyc   = 1'b1;
        mem_we    = 1'b1;
        mem_adr   = {r_tag[w_miss_set], w_miss_set};
        mem_dat_m = r_data[w_miss_set];
        if (mem_ack) w_next = FILL;
      end
      FILL: begin
        mem_stb = 1'b1;
        mem_cyc = 1'b1;
        mem_adr = r_miss_adr;
        if (mem_ack) w_next = COMPARE;
      end
      default: w_next = COMPARE;
    endcase
    if (rst) begin
      cpu_ack = 1'b0;
      mem_stb = 1'b0;
      mem_cyc = 1'b0;
      mem_we  = 1'b0;
    end
    mem_sel = mem_stb ? 16'hFFFF : 16'h0000;
  end

  // valid/dirty bookkeeping; reset drops every line, dirty or not
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_cmp_hit && cpu_we) begin
      r_dirty[w_set] <= 1'b1;
    end else if (w_wb_done) begin
      r_dirty[w_miss_set] <= 1'b0;
    end else if (w_fill_done) begin
      r_valid[w_miss_set] <= 1'b1;
      r_dirty[w_miss_set] <= 1'b0;
    end
  end

  // line data, tags and the latched miss address (installs even if the CPU has gone away)
  always_ff @(posedge clk) begin
    if (w_cmp_miss) r_miss_adr <= cpu_adr;
    if (!rst) begin
      if (w_cmp_hit && cpu_we) begin
        r_data[w_set] <= w_merged;
      end else if (w_fill_done) begin
        r_data[w_miss_set] <= mem_dat_s;
        r_tag[w_miss_set]  <= r_miss_adr[11:SET_BITS];
      end
    end
  end

`ifdef L1_CACHE_STATS_EN
  logic                 r_replay;
  logic                 r_abandon;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;

  // replay flag marks the first COMPARE after a fill that still has its requester
  always_ff @(posedge clk) begin
    if (rst) begin
      r_replay  <= 1'b0;
      r_abandon <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_replay  <= 1'b0;
      r_abandon <= 1'b0;
    end else begin
      if (!w_req) r_abandon <= 1'b1;
      if (w_fill_done) r_replay <= w_req && !r_abandon;
    end
  end

  // hit/miss counters, each request counted once
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_cmp_hit && !r_replay) r_hit_count <= r_hit_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      if (w_cmp_miss) r_miss_count <= r_miss_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l1_wb_cache.sv
// tb/tb_l1_wb_cache.sv - scoreboard bench for l1_wb_cache against a transparent-memory reference model
module tb_l1_wb_cache;
  logic         clk = 1'b0;
  logic         rst;
  logic [11:0]  cpu_adr;
  logic [127:0] cpu_dat_m;
  logic [127:0] cpu_dat_s;
  logic [15:0]  cpu_sel;
  logic         cpu_we, cpu_stb, cpu_cyc, cpu_ack;
  logic [11:0]  mem_adr;
  logic [127:0] mem_dat_m, mem_dat_s;
  logic [15:0]  mem_sel;
  logic         mem_we, mem_stb, mem_cyc, mem_ack;
  logic [15:0]  hit_count, miss_count;

`ifdef L1_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  l1_wb_cache #(.SET_BITS(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m), .cpu_dat_s(cpu_dat_s), .cpu_sel(cpu_sel),
    .cpu_we(cpu_we), .cpu_stb(cpu_stb), .cpu_cyc(cpu_cyc), .cpu_ack(cpu_ack),
    .mem_adr(mem_adr), .mem_dat_m(mem_dat_m), .mem_dat_s(mem_dat_s), .mem_sel(mem_sel),
    .mem_we(mem_we), .mem_stb(mem_stb), .mem_cyc(mem_cyc), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic         we;
    logic [127:0] data;
    int           lat;
    logic [15:0]  hc;
    logic [15:0]  mc;
  } exp_t;
  typedef struct {
    logic         we;
    logic [11:0]  adr;
    logic [127:0] data;
  } mem_exp_t;

  exp_t         exp_q[$];
  mem_exp_t     mem_q[$];
  logic [127:0] ref_mem [logic [11:0]];
  logic [127:0] l2_mem  [logic [11:0]];
  bit           mv [8];
  bit           md [8];
  logic [8:0]   mt [8];
  logic [15:0]  m_hc = 16'h0;
  logic [15:0]  m_mc = 16'h0;
  int           l2_delay = 2;
  int           req_start = 0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [127:0] init_line(input logic [11:0] a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    return {w, ~w, w ^ 32'h0F0F0F0F, w + 32'd7};
  endfunction

  function automatic logic [127:0] get_ref(input logic [11:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_line(a);
  endfunction

  function automatic logic [127:0] get_l2(input logic [11:0] a);
    if (l2_mem.exists(a)) return l2_mem[a];
    return init_line(a);
  endfunction

  // Issue one request: update the reference model, queue expectations, wait for the ack.
  task automatic do_req(input logic [11:0] a, input logic w, input logic [15:0] s,
                        input logic [127:0] d, input int idle);
    int           set;
    bit           hit;
    exp_t         e;
    mem_exp_t     me;
    logic [127:0] line;
    int           n;
    set  = int'(a[2:0]);
    hit  = mv[set] && (mt[set] == a[11:3]);
    e.hc = m_hc;
    if (!hit) begin
      if (mv[set] && md[set]) begin
        me.we = 1'b1; me.adr = {mt[set], a[2:0]}; me.data = get_ref(me.adr);
        mem_q.push_back(me);
        e.lat = 2 * l2_delay + 1;
      end else begin
        e.lat = l2_delay + 1;
      end
      me.we = 1'b0; me.adr = a; me.data = 128'h0;
      mem_q.push_back(me);
      mv[set] = 1'b1; mt[set] = a[11:3]; md[set] = 1'b0;
      m_mc++;
    end else begin
      e.lat = 0;
      m_hc++;
    end
    e.mc = m_mc;
    if (w) begin
      line = get_ref(a);
      for (int i = 0; i < 16; i++) if (s[i]) line[8*i +: 8] = d[8*i +: 8];
      ref_mem[a] = line;
      md[set] = 1'b1;
    end
    e.we   = w;
    e.data = get_ref(a);
    exp_q.push_back(e);
    if (idle > 0) begin
      cpu_stb = 1'b0; cpu_cyc = 1'b0;
      repeat (idle) @(posedge clk);
      #1;
    end
    cpu_adr = a; cpu_we = w; cpu_sel = s; cpu_dat_m = d;
    cpu_stb = 1'b1; cpu_cyc = 1'b1;
    req_start = cycle;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack && n < 60);
    if (!cpu_ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout actual=no_ack required=ack adr=%h", a);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every acked cycle pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && cpu_ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack actual=ack required=none adr=%h", cpu_adr);
      end else begin
        e = exp_q.pop_front();
        check("ack_latency", 128'(cycle - req_start), 128'(e.lat));
        if (!e.we) check("read_data", cpu_dat_s, e.data);
        check("hit_count", 128'(hit_count), 128'(STATS ? e.hc : 16'h0));
        check("miss_count", 128'(miss_count), 128'(STATS ? e.mc : 16'h0));
      end
    end
  end

  // L2 responder: acks each transaction after l2_delay cycles and checks it against the queue.
  initial begin
    int       wcnt;
    mem_exp_t me;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_dat_s = 128'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !(mem_stb && mem_cyc)) begin
        wcnt = 0;
      end else if (wcnt < l2_delay - 1) begin
        wcnt++;
      end else begin
        wcnt = 0;
        mem_ack = 1'b1;
        if (mem_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem actual=adr_%h required=none", mem_adr);
        end else begin
          me = mem_q.pop_front();
          check("mem_we", 128'(mem_we), 128'(me.we));
          check("mem_adr", 128'(mem_adr), 128'(me.adr));
          check("mem_sel", 128'(mem_sel), 128'(16'hFFFF));
          if (mem_we) begin
            check("wb_data", mem_dat_m, me.data);
            l2_mem[mem_adr] = mem_dat_m;
          end else begin
            mem_dat_s = get_l2(mem_adr);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    cpu_adr = 12'h0; cpu_dat_m = 128'h0; cpu_sel = 16'h0;
    cpu_we = 1'b0; cpu_stb = 1'b0; cpu_cyc = 1'b0;
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mt[i] = 9'h0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_cpu_ack", 128'(cpu_ack), 128'(1'b0));
    check("reset_mem_stb", 128'(mem_stb), 128'(1'b0));
    check("reset_hit_count", 128'(hit_count), 128'(16'h0));
    check("reset_miss_count", 128'(miss_count), 128'(16'h0));
    @(posedge clk);
    #1;

    l2_mem[12'h010]  = {16{8'hA5}};
    ref_mem[12'h010] = {16{8'hA5}};
    l2_delay = 3;
    do_req(12'h010, 1'b0, 16'h0, 128'h0, 0);
    l2_delay = 2;
    do_req(12'h010, 1'b0, 16'h0, 128'h0, 1);
    do_req(12'h010, 1'b1, 16'h0003, {112'h0, 16'hBEEF}, 1);
    do_req(12'h010, 1'b0, 16'h0, 128'h0, 1);
    do_req(12'h018, 1'b0, 16'h0, 128'h0, 1);
    for (int i = 0; i < 4; i++) do_req(12'h018, 1'b0, 16'h0, 128'h0, 0);

    // reset in the middle of a fill
    l2_delay = 6;
    cpu_adr = 12'h021; cpu_we = 1'b0; cpu_stb = 1'b1; cpu_cyc = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("fill_in_progress", 128'(mem_stb), 128'(1'b1));
    rst = 1'b1; cpu_stb = 1'b0; cpu_cyc = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midfill_reset_mem_stb", 128'(mem_stb), 128'(1'b0));
    check("midfill_reset_hit_count", 128'(hit_count), 128'(16'h0));
    check("midfill_reset_miss_count", 128'(miss_count), 128'(16'h0));
    for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
    m_hc = 16'h0; m_mc = 16'h0;
    ref_mem = l2_mem;
    mem_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    l2_delay = 2;
    do_req(12'h018, 1'b0, 16'h0, 128'h0, 0);

    // randomized traffic over a few tags per set
    for (int k = 0; k < 300; k++) begin
      l2_delay = $urandom_range(1, 3);
      do_req({9'($urandom_range(0, 3)), 3'($urandom_range(0, 7))},
             1'($urandom_range(0, 1)), 16'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 1));
    end

    cpu_stb = 1'b0; cpu_cyc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("final_exp_q_empty", 128'(exp_q.size()), 128'(0));
    check("final_mem_q_empty", 128'(mem_q.size()), 128'(0));
    check("final_hit_count", 128'(hit_count), 128'(STATS ? m_hc : 16'h0));
    check("final_miss_count", 128'(miss_count), 128'(STATS ? m_mc : 16'h0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
